// File: rtl/lii_eeof_inserter_if.sv
// lii_eeof_inserter_if
// Bundles the plain framed input stream and the LII output stream of the
// early-EOF inserter. The master side is the upstream source and the LII
// consumer. The slave side is the inserter itself.
interface lii_eeof_inserter_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int BV_W = $clog2(DATA_WIDTH / 8) + 1;

    // plain framed input stream
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sof;
    logic                  in_eof;
    logic [BV_W-1:0]       in_bytes_vld;
    logic                  in_vld;

    // LII output stream with early end-of-frame signalling
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eof;
    logic [BV_W-1:0]       bytes_vld;
    logic                  eeof;
    logic [BV_W-1:0]       edb;
    logic                  rdy;
    logic                  err;
    logic [15:0]           err_cnt;

    modport master (
        output in_data, in_sof, in_eof, in_bytes_vld, in_vld,
        input  data, sof, eof, bytes_vld, eeof, edb, rdy, err, err_cnt
    );

    modport slave (
        input  in_data, in_sof, in_eof, in_bytes_vld, in_vld,
        output data, sof, eof, bytes_vld, eeof, edb, rdy, err, err_cnt
    );
endinterface

// File: rtl/lii_eeof_inserter.sv
// lii_eeof_inserter
// Converts a plain SOF/EOF framed word stream into an LII stream that flags
// the end of a frame one word early (EEOF + EDB). One word is held back so
// the word before an EOF word already knows that the EOF word follows.
// Optional feature: define LII_EEOF_INSERTER_STRICT_BV_EN to treat an EOF
// word with BYTES_VLD of 0 or above DATA_WIDTH/8 as a protocol error and to
// clamp its byte count to DATA_WIDTH/8.
module lii_eeof_inserter #(
    parameter int DATA_WIDTH = 64
) (
    input logic               clk,
    input logic               reset,
    lii_eeof_inserter_if.slave bus
);
    localparam int BV_W = $clog2(DATA_WIDTH / 8) + 1;
    localparam logic [BV_W-1:0] FULL_BV = BV_W'(DATA_WIDTH / 8);

    // lookahead buffer and frame tracking
    logic                  buf_vld;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_sof;
    logic                  buf_eof;
    logic [BV_W-1:0]       buf_bv;
    logic                  in_frame;
    logic                  skip;

    // registered outputs
    logic [DATA_WIDTH-1:0] data_q;
    logic                  sof_q;
    logic                  eof_q;
    logic [BV_W-1:0]       bytes_vld_q;
    logic                  eeof_q;
    logic [BV_W-1:0]       edb_q;
    logic                  rdy_q;
    logic                  err_q;
    logic [15:0]           err_cnt_q;

    // per-cycle decode
    logic            single_err;
    logic            restart;
    logic            stray;
    logic            orphan_err;
    logic            accept;
    logic            emit_eof;
    logic            emit_eeof;
    logic            bv_err;
    logic            err_now;
    logic [BV_W-1:0] in_bv_eff;

`ifdef LII_EEOF_INSERTER_STRICT_BV_EN
    logic bv_bad;

    // Out-of-range byte counts on an EOF word are flagged and clamped to a full word
    always_comb begin
        bv_bad    = (bus.in_bytes_vld == '0) || (bus.in_bytes_vld > FULL_BV);
        in_bv_eff = bv_bad ? FULL_BV : bus.in_bytes_vld;
        bv_err    = accept && bus.in_eof && bv_bad;
    end
`else
    // Byte counts are passed through unchecked
    always_comb begin
        in_bv_eff = bus.in_bytes_vld;
        bv_err    = 1'b0;
    end
`endif

    // Classify the incoming word and decide what the buffer emits this cycle
    always_comb begin
        single_err = bus.in_vld && bus.in_sof && bus.in_eof;
        restart    = bus.in_vld && bus.in_sof && in_frame;
        stray      = bus.in_vld && !bus.in_sof && !in_frame;
        orphan_err = stray && !skip;
        accept     = bus.in_vld && !single_err && !stray;
        emit_eof   = buf_vld && (buf_eof || restart);
        emit_eeof  = buf_vld && !buf_eof && !restart && accept;
        err_now    = single_err || restart || orphan_err || bv_err;
    end

    // Buffer update, output registers, frame tracking and error counting
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_vld     <= 1'b0;
            buf_data    <= '0;
            buf_sof     <= 1'b0;
            buf_eof     <= 1'b0;
            buf_bv      <= '0;
            in_frame    <= 1'b0;
            skip        <= 1'b1;
            data_q      <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            bytes_vld_q <= '0;
            eeof_q      <= 1'b0;
            edb_q       <= '0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (emit_eof) begin
                data_q      <= buf_data;
                sof_q       <= buf_sof;
                eof_q       <= 1'b1;
                bytes_vld_q <= buf_bv;
                eeof_q      <= 1'b0;
                edb_q       <= '0;
            end else if (emit_eeof) begin
                data_q      <= buf_data;
                sof_q       <= buf_sof;
                eof_q       <= 1'b0;
                bytes_vld_q <= buf_bv;
                eeof_q      <= bus.in_eof;
                edb_q       <= bus.in_eof ? in_bv_eff : '0;
            end
            rdy_q <= emit_eof || emit_eeof;

            if (accept) begin
                buf_vld  <= 1'b1;
                buf_data <= bus.in_data;
                buf_sof  <= bus.in_sof;
                buf_eof  <= bus.in_eof;
                buf_bv   <= bus.in_eof ? in_bv_eff : FULL_BV;
            end else if (emit_eof) begin
                buf_vld <= 1'b0;
            end

            if (accept && bus.in_sof) begin
                in_frame <= 1'b1;
            end else if (accept && bus.in_eof) begin
                in_frame <= 1'b0;
            end else if (restart) begin
                in_frame <= 1'b0;
            end

            if (bus.in_vld && bus.in_sof) begin
                skip <= 1'b0;
            end

            err_q <= err_now;
            if (err_now && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.sof       = sof_q;
    assign bus.eof       = eof_q;
    assign bus.bytes_vld = bytes_vld_q;
    assign bus.eeof      = eeof_q;
    assign bus.edb       = edb_q;
    assign bus.rdy       = rdy_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_lii_eeof_inserter.sv
// tb_lii_eeof_inserter
// Table-driven bench for the LII early-EOF inserter. Expected LII words are
// queued as stimulus is driven and popped when the inserter raises RDY.
module tb_lii_eeof_inserter;
    localparam int DATA_WIDTH = 64;
    localparam int BV_W = $clog2(DATA_WIDTH / 8) + 1;
`ifdef LII_EEOF_INSERTER_STRICT_BV_EN
    localparam logic STRICT = 1'b1;
`else
    localparam logic STRICT = 1'b0;
`endif
    localparam logic [BV_W-1:0] EDB_BV = STRICT ? BV_W'(8) : BV_W'(0);
    localparam logic [15:0]     CNT_BV = STRICT ? 16'd4 : 16'd3;

    typedef struct packed {
        logic                  sof;
        logic                  eof;
        logic [BV_W-1:0]       bv;
        logic                  eeof;
        logic [BV_W-1:0]       edb;
        logic [DATA_WIDTH-1:0] data;
    } out_t;

    typedef struct {
        logic                  vld;
        logic                  sof;
        logic                  eof;
        logic [BV_W-1:0]       bv;
        logic [DATA_WIDTH-1:0] din;
        logic                  exp_rdy;
        out_t                  exp_out;
        logic                  exp_err;
        logic [15:0]           exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    out_t expq[$];
    vec_t vecs[$];

    lii_eeof_inserter_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    lii_eeof_inserter #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // input-only row: nothing expected on the LII side
    function automatic vec_t vi(input logic vld, input logic sof, input logic eof,
                                input logic [BV_W-1:0] bv, input logic [63:0] din,
                                input logic err, input logic [15:0] cnt);
        vec_t t;
        t.vld = vld; t.sof = sof; t.eof = eof; t.bv = bv; t.din = din;
        t.exp_rdy = 1'b0;
        t.exp_out = '0;
        t.exp_err = err;
        t.exp_cnt = cnt;
        return t;
    endfunction

    // row that expects one LII word after the clock edge
    function automatic vec_t vo(input logic vld, input logic sof, input logic eof,
                                input logic [BV_W-1:0] bv, input logic [63:0] din,
                                input logic osof, input logic oeof, input logic [BV_W-1:0] obv,
                                input logic oeeof, input logic [BV_W-1:0] oedb,
                                input logic [63:0] odata,
                                input logic err, input logic [15:0] cnt);
        vec_t t;
        t = vi(vld, sof, eof, bv, din, err, cnt);
        t.exp_rdy = 1'b1;
        t.exp_out.sof  = osof;
        t.exp_out.eof  = oeof;
        t.exp_out.bv   = obv;
        t.exp_out.eeof = oeeof;
        t.exp_out.edb  = oedb;
        t.exp_out.data = odata;
        return t;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t t);
        bus.in_vld       = t.vld;
        bus.in_sof       = t.sof;
        bus.in_eof       = t.eof;
        bus.in_bytes_vld = t.bv;
        bus.in_data      = t.din;
        if (t.exp_rdy) expq.push_back(t.exp_out);
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input vec_t t, input string tag);
        out_t want;
        check_val({tag, ".rdy"}, 64'(bus.rdy), 64'(t.exp_rdy));
        check_val({tag, ".err"}, 64'(bus.err), 64'(t.exp_err));
        check_val({tag, ".err_cnt"}, 64'(bus.err_cnt), 64'(t.exp_cnt));
        if (bus.rdy) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s.unexpected_word: got data 0x%0h, expected no word", tag, bus.data);
            end else begin
                want = expq.pop_front();
                check_val({tag, ".data"}, bus.data, want.data);
                check_val({tag, ".sof"}, 64'(bus.sof), 64'(want.sof));
                check_val({tag, ".eof"}, 64'(bus.eof), 64'(want.eof));
                check_val({tag, ".bytes_vld"}, 64'(bus.bytes_vld), 64'(want.bv));
                check_val({tag, ".eeof"}, 64'(bus.eeof), 64'(want.eeof));
                check_val({tag, ".edb"}, 64'(bus.edb), 64'(want.edb));
            end
        end else if (expq.size() != 0) begin
            void'(expq.pop_front());
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".data"}, bus.data, 64'd0);
        check_val({tag, ".sof"}, 64'(bus.sof), 64'd0);
        check_val({tag, ".eof"}, 64'(bus.eof), 64'd0);
        check_val({tag, ".bytes_vld"}, 64'(bus.bytes_vld), 64'd0);
        check_val({tag, ".eeof"}, 64'(bus.eeof), 64'd0);
        check_val({tag, ".edb"}, 64'(bus.edb), 64'd0);
        check_val({tag, ".rdy"}, 64'(bus.rdy), 64'd0);
        check_val({tag, ".err"}, 64'(bus.err), 64'd0);
        check_val({tag, ".err_cnt"}, 64'(bus.err_cnt), 64'd0);
    endtask

    task automatic run_row(input vec_t t, input string tag);
        apply_stimulus(t);
        check_output(t, tag);
    endtask

    initial begin
        // back-to-back 3-word frame ending with 5 bytes
        vecs.push_back(vi(1, 1, 0, 8, 64'hA1A1_0000_0000_0001, 0, 0));
        vecs.push_back(vo(1, 0, 0, 8, 64'hA1A1_0000_0000_0002, 1, 0, 8, 0, 0, 64'hA1A1_0000_0000_0001, 0, 0));
        vecs.push_back(vo(1, 0, 1, 5, 64'hA1A1_0000_0000_0003, 0, 0, 8, 1, 5, 64'hA1A1_0000_0000_0002, 0, 0));
        vecs.push_back(vo(0, 0, 0, 0, 64'h0,                   0, 1, 5, 0, 0, 64'hA1A1_0000_0000_0003, 0, 0));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, 0));
        // 4-word frame with a 3-cycle gap before the EOF word
        vecs.push_back(vi(1, 1, 0, 8, 64'hB2B2_0000_0000_0011, 0, 0));
        vecs.push_back(vo(1, 0, 0, 2, 64'hB2B2_0000_0000_0012, 1, 0, 8, 0, 0, 64'hB2B2_0000_0000_0011, 0, 0));
        vecs.push_back(vo(1, 0, 0, 8, 64'hB2B2_0000_0000_0013, 0, 0, 8, 0, 0, 64'hB2B2_0000_0000_0012, 0, 0));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, 0));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, 0));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, 0));
        vecs.push_back(vo(1, 0, 1, 3, 64'hB2B2_0000_0000_0014, 0, 0, 8, 1, 3, 64'hB2B2_0000_0000_0013, 0, 0));
        vecs.push_back(vo(0, 0, 0, 0, 64'h0,                   0, 1, 3, 0, 0, 64'hB2B2_0000_0000_0014, 0, 0));
        // frame A immediately followed by frame B
        vecs.push_back(vi(1, 1, 0, 8, 64'hC3C3_0000_0000_0021, 0, 0));
        vecs.push_back(vo(1, 0, 1, 2, 64'hC3C3_0000_0000_0022, 1, 0, 8, 1, 2, 64'hC3C3_0000_0000_0021, 0, 0));
        vecs.push_back(vo(1, 1, 0, 8, 64'hC3C3_0000_0000_0031, 0, 1, 2, 0, 0, 64'hC3C3_0000_0000_0022, 0, 0));
        vecs.push_back(vo(1, 0, 1, 7, 64'hC3C3_0000_0000_0032, 1, 0, 8, 1, 7, 64'hC3C3_0000_0000_0031, 0, 0));
        vecs.push_back(vo(0, 0, 0, 0, 64'h0,                   0, 1, 7, 0, 0, 64'hC3C3_0000_0000_0032, 0, 0));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, 0));
        // single-word frame is dropped and counted
        vecs.push_back(vi(1, 1, 1, 4, 64'hD4D4_0000_0000_0041, 1, 1));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, 1));
        // SOF mid-frame terminates the old frame, new frame follows intact
        vecs.push_back(vi(1, 1, 0, 8, 64'hE5E5_0000_0000_0051, 0, 1));
        vecs.push_back(vo(1, 0, 0, 8, 64'hE5E5_0000_0000_0052, 1, 0, 8, 0, 0, 64'hE5E5_0000_0000_0051, 0, 1));
        vecs.push_back(vo(1, 1, 0, 8, 64'hE6E6_0000_0000_0061, 0, 1, 8, 0, 0, 64'hE5E5_0000_0000_0052, 1, 2));
        vecs.push_back(vo(1, 0, 0, 8, 64'hE6E6_0000_0000_0062, 1, 0, 8, 0, 0, 64'hE6E6_0000_0000_0061, 0, 2));
        vecs.push_back(vo(1, 0, 1, 1, 64'hE6E6_0000_0000_0063, 0, 0, 8, 1, 1, 64'hE6E6_0000_0000_0062, 0, 2));
        vecs.push_back(vo(0, 0, 0, 0, 64'h0,                   0, 1, 1, 0, 0, 64'hE6E6_0000_0000_0063, 0, 2));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, 2));
        // non-SOF word outside a frame is dropped and counted
        vecs.push_back(vi(1, 0, 0, 8, 64'hF7F7_0000_0000_0071, 1, 3));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, 3));
        // EOF word with zero byte count
        vecs.push_back(vi(1, 1, 0, 8, 64'h9898_0000_0000_0081, 0, 3));
        vecs.push_back(vo(1, 0, 1, 0, 64'h9898_0000_0000_0082, 1, 0, 8, 1, EDB_BV, 64'h9898_0000_0000_0081, STRICT, CNT_BV));
        vecs.push_back(vo(0, 0, 0, 0, 64'h0,                   0, 1, EDB_BV, 0, 0, 64'h9898_0000_0000_0082, 0, CNT_BV));
        vecs.push_back(vi(0, 0, 0, 0, 64'h0, 0, CNT_BV));

        reset            = 1'b1;
        bus.in_vld       = 1'b0;
        bus.in_sof       = 1'b0;
        bus.in_eof       = 1'b0;
        bus.in_bytes_vld = '0;
        bus.in_data      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], $sformatf("vec%0d", i));
        end

        // reset mid-frame, then stray words, then a clean 2-word frame
        run_row(vi(1, 1, 0, 8, 64'h5A5A_0000_0000_0091, 0, CNT_BV), "rst_a");
        run_row(vo(1, 0, 0, 8, 64'h5A5A_0000_0000_0092, 1, 0, 8, 0, 0, 64'h5A5A_0000_0000_0091, 0, CNT_BV), "rst_b");
        reset            = 1'b1;
        bus.in_vld       = 1'b1;
        bus.in_sof       = 1'b0;
        bus.in_eof       = 1'b0;
        bus.in_data      = 64'h5A5A_0000_0000_0093;
        @(posedge clk);
        #1;
        check_reset_state("rst_mid");
        reset = 1'b0;
        run_row(vi(1, 0, 0, 8, 64'h5A5A_0000_0000_0094, 0, 0), "rst_skip0");
        run_row(vi(1, 0, 1, 3, 64'h5A5A_0000_0000_0095, 0, 0), "rst_skip1");
        run_row(vi(1, 1, 0, 8, 64'h5A5A_0000_0000_0096, 0, 0), "rst_c");
        run_row(vo(1, 0, 1, 6, 64'h5A5A_0000_0000_0097, 1, 0, 8, 1, 6, 64'h5A5A_0000_0000_0096, 0, 0), "rst_d");
        run_row(vo(0, 0, 0, 0, 64'h0,                   0, 1, 6, 0, 0, 64'h5A5A_0000_0000_0097, 0, 0), "rst_e");
        run_row(vi(0, 0, 0, 0, 64'h0, 0, 0), "rst_f");

        check_val("queue_empty", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lii_eeof_inserter.md
Name: lii_eeof_inserter

Overview:
- Source-side adapter that converts a plain framed word stream (SOF/EOF/BYTES_VLD/VLD) into an LII stream carrying fast-SOF early end-of-frame signalling: EEOF plus EDB, one word ahead of EOF.
- Sits directly upstream of the LII consumer (RX MAC user side / LII agent DUT boundary).
- Holds one word of lookahead so that EEOF and EDB are known when the preceding word is emitted.
- No backpressure on either side: input VLD and output RDY are qualifying strobes only.

Parameters:
- DATA_WIDTH, 64, word width in bits; multiple of 8, minimum 16.
- BV_W, $clog2(DATA_WIDTH/8)+1, width of BYTES_VLD and EDB (derived, not overridable).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- IN_DATA  in  DATA_WIDTH  input word.
- IN_SOF  in  1  first word of frame.
- IN_EOF  in  1  last word of frame.
- IN_BYTES_VLD  in  BV_W  valid bytes in the EOF word; ignored otherwise.
- IN_VLD  in  1  input word present.
- DATA  out  DATA_WIDTH  LII data.
- SOF  out  1  LII start of frame.
- EOF  out  1  LII end of frame.
- BYTES_VLD  out  BV_W  valid bytes; DATA_WIDTH/8 on non-EOF words.
- EEOF  out  1  the next emitted word is EOF.
- EDB  out  BV_W  BYTES_VLD of the next (EOF) word; 0 when EEOF=0.
- RDY  out  1  LII word valid this cycle.
- ERR  out  1  one-cycle pulse on an input protocol error.
- ERR_CNT  out  16  saturating count of protocol errors.

Behaviour:
- State:
  - buf_vld, plus buffered word fields (data, sof, eof, bv).
  - in_frame flag: set on an accepted SOF; cleared on an accepted EOF.
- Reset: all outputs are registered and equal 0 the cycle after RESET is sampled high; buffer emptied; in_frame=0; ERR_CNT=0.
- Reset mid-frame: the partial frame is discarded. Input words after reset are dropped until the next SOF; these drops are not counted.
- Emission rule, evaluated each cycle with an accepted input word A (accepted = IN_VLD and not dropped):
  - buf_vld=1 and buf.eof=0 and A present: emit buf with EEOF=A.eof and EDB=(A.eof ? A.bv : 0); buf<=A.
  - buf_vld=1 and buf.eof=1: emit buf unconditionally, with EEOF=0. If A is present, buf<=A; otherwise buf empties.
  - buf_vld=1, buf.eof=0, no A: nothing emitted (RDY=0); buf holds, so there is an arbitrary mid-frame gap.
  - buf_vld=0 and A present: buf<=A; nothing emitted.
- Consequences:
  - Latency is 1 cycle for back-to-back input.
  - An EOF word is always emitted exactly one cycle after its EEOF word, with RDY=1.
  - EDB always equals the BYTES_VLD of the following EOF word.
  - A new SOF is never emitted before the previous frame's EOF.
- Protocol errors (ERR pulses the cycle after the offending input, and ERR_CNT increments, saturating at 0xFFFF):
  - IN_SOF&IN_EOF (single-word frame): the word is dropped, because no preceding word can carry its EEOF.
  - IN_SOF while in_frame=1: the buffered word is emitted with EOF forced to 1 (EEOF=0 on it, BYTES_VLD=DATA_WIDTH/8). The new frame then proceeds normally.
  - A word without IN_SOF while in_frame=0 (outside the post-reset skip): the word is dropped.
  - Simultaneous errors in one cycle count once.
- BYTES_VLD input:
  - Values 0 or greater than DATA_WIDTH/8 on an EOF word are passed through unchanged.
  - No check is made on these values.

Optional Feature:
- Macro: LII_EEOF_INSERTER_STRICT_BV_EN.
- Defined: an EOF word with IN_BYTES_VLD==0 or >DATA_WIDTH/8 is a protocol error (ERR, ERR_CNT++), and its BYTES_VLD and EDB are clamped to DATA_WIDTH/8.
- Undefined: values are passed through unchecked, as described above.

Test Plan:
- Back-to-back 3-word frame, DATA_WIDTH=64, last BV=5 -> RDY on 3 consecutive cycles starting 2 cycles after the first IN_VLD; word 2 has EEOF=1, EDB=5; word 3 has EOF=1, BYTES_VLD=5; ERR never asserted.
- 4-word frame with a 3-cycle IN_VLD gap before the EOF word -> RDY stays 0 during the gap; the EEOF word and EOF word appear on consecutive cycles; EDB equals the EOF BYTES_VLD.
- Frame A ends and frame B's SOF follows on the next input cycle -> A's EOF is emitted, then B's SOF; EEOF=0 on A's EOF word; no SOF appears between A's SOF and EOF.
- Single-word frame (IN_SOF=IN_EOF=1) -> no LII output for it; ERR pulses once; ERR_CNT=1.
- SOF arriving mid-frame after 2 words -> the buffered word is emitted with EOF=1, BYTES_VLD=8; ERR pulses; the new frame is then output intact.
- RESET asserted mid-frame, then 2 non-SOF words, then a valid 2-word frame -> all outputs are 0 the cycle after reset; the non-SOF words are dropped with ERR_CNT=0; the following frame is output correctly.
